// File: rtl/piso_reg_if.sv
// piso_reg_if: load/data handshake and serial outputs of the PISO serialiser
interface piso_reg_if #(parameter int WIDTH = 4);
  logic             load;
  logic [WIDTH-1:0] parallelIn;
  logic             ready;
  logic             serialOut;
  logic             busy;
  logic             done;
  modport master (output load, parallelIn, input ready, serialOut, busy, done);
  modport slave (input load, parallelIn, output ready, serialOut, busy, done);
endinterface

// File: rtl/piso_reg.sv
// piso_reg: LSB-first parallel-in serial-out shifter; macro PISO_PARITY_EN appends an even parity bit
module piso_reg #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  piso_reg_if.slave  io
);
  localparam int CW = $clog2(WIDTH);
`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             last_data, last, accept;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif
  assign io.ready     = (state_q == IDLE) || last;
  assign io.serialOut = sreg_q[0];
  assign io.busy      = state_q != IDLE;
  assign io.done      = done_q;
  assign accept       = io.load && io.ready;
  // final bit period of a frame: the parity bit when enabled, else data bit WIDTH-1
  always_comb begin
    last_data = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
`ifdef PISO_PARITY_EN
    last = state_q == PARITY;
`else
    last = last_data;
`endif
  end
  // next state: accept restarts the frame (even in the last bit), otherwise shift or drop to idle
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = last;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      sreg_d  = io.parallelIn;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^io.parallelIn;
`endif
    end else if (last) begin
      state_d = IDLE;
      sreg_d  = '0;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
    end else if (last_data) begin
      state_d = PARITY;
      sreg_d  = WIDTH'(par_q);
`endif
    end else if (state_q == SHIFT) begin
      sreg_d = sreg_q >> 1;
      cnt_d  = cnt_q + CW'(1);
    end
  end
  // state registers with synchronous active-low reset taking priority over everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule
